cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the limited result-broadcast (common data bus, CDB) ports among the execution units: ALU, branch and load/store.
- Granted results drive the RRF forward-write ports, the ROB finish ports and the reservation-station wakeup buses.
- Each requester has a one-entry holding buffer with a valid/ready handshake.
- Occupied buffers are granted to up to CDB_NUM buses per cycle in round-robin order; bus outputs are registered.

Parameters:
REQ_NUM, 3, number of requesting execution units (index 0 = ALU, 1 = branch, 2 = load/store)
CDB_NUM, 2, number of result buses; must be 1 to REQ_NUM
DATA_LEN, 32, result width
RRF_SEL, 6, RRF tag width
SRC_SEL, 2, requester-index width; must satisfy 2^SRC_SEL >= REQ_NUM

Ports:
clk_i  in  1  clock; all state updates on rising edge
reset_i  in  1  asynchronous, active-low reset
flush_i  in  1  pipeline kill; drops all buffered and in-flight results
req_valid_i  in  REQ_NUM  requester k presents a result
req_ready_o  out  REQ_NUM  requester k's buffer can accept this cycle
req_data_i  in  REQ_NUM*DATA_LEN  result data; slice k = requester k
req_tag_i  in  REQ_NUM*RRF_SEL  destination RRF tag / ROB entry
req_rrf_we_i  in  REQ_NUM  result writes the RRF (0 = ROB completion only)
cdb_valid_o  out  CDB_NUM  bus b carries a result
cdb_data_o  out  CDB_NUM*DATA_LEN  bus data
cdb_tag_o  out  CDB_NUM*RRF_SEL  bus tag
cdb_rrf_we_o  out  CDB_NUM  bus RRF write enable; 0 whenever cdb_valid_o[b]=0
cdb_src_o  out  CDB_NUM*SRC_SEL  index of the requester that owns bus b

Behaviour:
- Reset (reset_i=0, async):
  - all buffers empty, rr_ptr=0;
  - all cdb_* outputs 0;
  - req_ready_o all 1 after release, since it is derived from the empty buffers.
- Buffer k holds valid, data, tag, rrf_we.
- Handshake:
  - req_ready_o[k] = !flush_i && (!buf_valid[k] || grant[k]), combinational from current state.
  - Transfer occurs when req_valid_i[k] && req_ready_o[k]; the buffer loads on that edge.
  - Requester data need not be held when req_ready_o[k]=0; the requester keeps it and retries.
- Arbitration (combinational, per cycle):
  - Scan buffer indices rr_ptr, rr_ptr+1, … mod REQ_NUM.
  - The first CDB_NUM occupied buffers are granted.
  - The first grant in scan order goes to bus 0, the second to bus 1, and so on.
- Bus registers, at the clock edge:
  - Bus b loads the granted buffer's contents, with cdb_valid_o[b]=1 and cdb_src_o[b]=index.
  - A bus with no grant loads valid=0 with data, tag, rrf_we and src all 0.
  - Each bus is valid for exactly one cycle per grant; there is no back-pressure from the bus.
- Buffer update at the same edge: a granted buffer with no new transfer clears; with a new transfer it reloads (full throughput, one result per cycle per requester).
- Latency: a result accepted at edge E0 appears on a CDB in the cycle after edge E1 at the earliest.
- rr_ptr update:
  - If any grant: rr_ptr <= (index of last granted buffer + 1) mod REQ_NUM.
  - Else: unchanged.
  - Fairness guarantee: an occupied buffer is granted within ceil(REQ_NUM/CDB_NUM) cycles.
- flush_i=1, at the edge:
  - all buffers cleared;
  - all cdb_valid_o and cdb_rrf_we_o 0 the next cycle;
  - no transfers accepted that cycle (ready forced 0);
  - rr_ptr retained.
- Simultaneous flush_i and req_valid_i: flush wins and the input is discarded.
- All buffers empty: no bus valid, rr_ptr held.
- Fewer occupied buffers than buses: the highest-numbered buses are idle.
- Wrap-around: the scan wraps from REQ_NUM-1 to 0 within one cycle.
- Tags are passed unmodified; duplicate tags are not checked.

Test Plan:
- Reset: hold reset_i=0, then release → all cdb_valid_o=0, req_ready_o=3'b111, rr_ptr=0.
- Single result: req_valid_i=3'b001, data=32'hDEADBEEF, tag=5, rrf_we=1 for one cycle at E0 → after E1, cdb_valid_o=2'b01, cdb_data_o[0]=32'hDEADBEEF, cdb_tag_o[0]=5, cdb_src_o[0]=0, cdb_rrf_we_o[0]=1; after E2 all buses idle.
- Contention, CDB_NUM=2:
  - All three requesters valid at E0.
  - First bus cycle: src 0 on bus 0, src 1 on bus 1; rr_ptr becomes 2.
  - Second bus cycle: src 2 on bus 0.
- Sustained load:
  - All three requesters stay valid for 12 cycles, accepting whenever req_ready_o=1.
  - Required: 24 results broadcast; no requester waits more than 2 cycles; bus order follows round-robin.
- Flush:
  - Buffers 0 and 2 occupied, flush_i=1 for one cycle, simultaneous with req_valid_i[1].
  - Required: req_ready_o=0 that cycle; next cycle cdb_valid_o=0; no later bus carries these tags.
- Store completion: req_rrf_we_i[2]=0 with valid result → cdb_valid_o=1, cdb_rrf_we_o=0, cdb_src_o=2 on the granted bus.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: requester handshake and result-bus bundle for cdb_arbiter.
interface cdb_arbiter_if #(
   parameter int REQ_NUM  = 3,
   parameter int CDB_NUM  = 2,
   parameter int DATA_LEN = 32,
   parameter int RRF_SEL  = 6,
   parameter int SRC_SEL  = 2
);
   logic                        flush_i;
   logic [REQ_NUM-1:0]          req_valid_i;
   logic [REQ_NUM-1:0]          req_ready_o;
   logic [REQ_NUM*DATA_LEN-1:0] req_data_i;
   logic [REQ_NUM*RRF_SEL-1:0]  req_tag_i;
   logic [REQ_NUM-1:0]          req_rrf_we_i;
   logic [CDB_NUM-1:0]          cdb_valid_o;
   logic [CDB_NUM*DATA_LEN-1:0] cdb_data_o;
   logic [CDB_NUM*RRF_SEL-1:0]  cdb_tag_o;
   logic [CDB_NUM-1:0]          cdb_rrf_we_o;
   logic [CDB_NUM*SRC_SEL-1:0]  cdb_src_o;
   modport master (
      output flush_i, req_valid_i, req_data_i, req_tag_i, req_rrf_we_i,
      input  req_ready_o, cdb_valid_o, cdb_data_o, cdb_tag_o, cdb_rrf_we_o, cdb_src_o
   );
   modport slave (
      input  flush_i, req_valid_i, req_data_i, req_tag_i, req_rrf_we_i,
      output req_ready_o, cdb_valid_o, cdb_data_o, cdb_tag_o, cdb_rrf_we_o, cdb_src_o
   );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: one-entry holding buffer per execution unit, round-robin granted onto registered result buses.
module cdb_arbiter #(
   parameter int REQ_NUM  = 3,
   parameter int CDB_NUM  = 2,
   parameter int DATA_LEN = 32,
   parameter int RRF_SEL  = 6,
   parameter int SRC_SEL  = 2
) (
   input logic          clk_i,
   input logic          reset_i,
   cdb_arbiter_if.slave bus_if
);
   logic [REQ_NUM-1:0]          buf_valid_q, buf_we_q;
   logic [DATA_LEN-1:0]         buf_data_q [REQ_NUM];
   logic [RRF_SEL-1:0]          buf_tag_q [REQ_NUM];
   logic [SRC_SEL-1:0]          rr_ptr_q, rr_ptr_d;
   logic [REQ_NUM-1:0]          grant, ready, accept;
   logic [CDB_NUM-1:0]          cdb_valid_q, cdb_valid_d, cdb_we_q, cdb_we_d;
   logic [CDB_NUM*DATA_LEN-1:0] cdb_data_q, cdb_data_d;
   logic [CDB_NUM*RRF_SEL-1:0]  cdb_tag_q, cdb_tag_d;
   logic [CDB_NUM*SRC_SEL-1:0]  cdb_src_q, cdb_src_d;

   // Scan position i maps to buffer (rr_ptr+i) mod REQ_NUM; the n-th occupied hit drives bus n.
   always_comb begin
      int cnt;
      cnt = 0;
      grant = '0;
      rr_ptr_d = rr_ptr_q;
      cdb_valid_d = '0;
      cdb_we_d = '0;
      cdb_data_d = '0;
      cdb_tag_d = '0;
      cdb_src_d = '0;
      for (int i = 0; i < REQ_NUM; i++)
         for (int j = 0; j < REQ_NUM; j++)
            if ((int'(rr_ptr_q) + i) % REQ_NUM == j && buf_valid_q[j] && cnt < CDB_NUM) begin
               grant[j] = 1'b1;
               for (int b = 0; b < CDB_NUM; b++)
                  if (b == cnt) begin
                     cdb_valid_d[b] = 1'b1;
                     cdb_we_d[b] = buf_we_q[j];
                     cdb_data_d[b*DATA_LEN +: DATA_LEN] = buf_data_q[j];
                     cdb_tag_d[b*RRF_SEL +: RRF_SEL] = buf_tag_q[j];
                     cdb_src_d[b*SRC_SEL +: SRC_SEL] = SRC_SEL'(j);
                  end
               rr_ptr_d = SRC_SEL'((j + 1) % REQ_NUM);
               cnt++;
            end
   end

   assign ready  = bus_if.flush_i ? '0 : (~buf_valid_q | grant);
   assign accept = bus_if.req_valid_i & ready;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         buf_valid_q <= '0;
         buf_we_q <= '0;
         rr_ptr_q <= '0;
         cdb_valid_q <= '0;
         cdb_we_q <= '0;
         cdb_data_q <= '0;
         cdb_tag_q <= '0;
         cdb_src_q <= '0;
         for (int k = 0; k < REQ_NUM; k++) begin
            buf_data_q[k] <= '0;
            buf_tag_q[k] <= '0;
         end
      end else if (bus_if.flush_i) begin
         buf_valid_q <= '0;
         cdb_valid_q <= '0;
         cdb_we_q <= '0;
         cdb_data_q <= '0;
         cdb_tag_q <= '0;
         cdb_src_q <= '0;
      end else begin
         buf_valid_q <= accept | (buf_valid_q & ~grant);
         rr_ptr_q <= rr_ptr_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_we_q <= cdb_we_d;
         cdb_data_q <= cdb_data_d;
         cdb_tag_q <= cdb_tag_d;
         cdb_src_q <= cdb_src_d;
         for (int k = 0; k < REQ_NUM; k++)
            if (accept[k]) begin
               buf_data_q[k] <= bus_if.req_data_i[k*DATA_LEN +: DATA_LEN];
               buf_tag_q[k] <= bus_if.req_tag_i[k*RRF_SEL +: RRF_SEL];
               buf_we_q[k] <= bus_if.req_rrf_we_i[k];
            end
      end
   end

   assign bus_if.req_ready_o  = ready;
   assign bus_if.cdb_valid_o  = cdb_valid_q;
   assign bus_if.cdb_rrf_we_o = cdb_we_q;
   assign bus_if.cdb_data_o   = cdb_data_q;
   assign bus_if.cdb_tag_o    = cdb_tag_q;
   assign bus_if.cdb_src_o    = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scoreboard bench for cdb_arbiter (3 requesters, 2 buses).
module tb_cdb_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   cdb_arbiter_if #(.REQ_NUM(3), .CDB_NUM(2), .DATA_LEN(32), .RRF_SEL(6), .SRC_SEL(2)) bus_if ();
   cdb_arbiter #(.REQ_NUM(3), .CDB_NUM(2), .DATA_LEN(32), .RRF_SEL(6), .SRC_SEL(2)) dut (
      .clk_i(clk), .reset_i(rst_n), .bus_if(bus_if)
   );

   typedef struct packed {
      logic [1:0]  src;
      logic [31:0] d;
      logic [5:0]  t;
      logic        we;
   } item_t;

   item_t sbq[$];
   int n_chk = 0;
   int n_fail = 0;
   int nres = 0;
   logic [2:0] acc;
   logic [23:0] seq [3];
   logic [3:0] pat [3] = '{4'b0100, 4'b0010, 4'b1001};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int k, input logic v, input logic [31:0] d, input logic [5:0] t, input logic we);
      bus_if.req_valid_i[k] = v;
      bus_if.req_data_i[k*32 +: 32] = d;
      bus_if.req_tag_i[k*6 +: 6] = t;
      bus_if.req_rrf_we_i[k] = we;
   endtask

   // Captures handshakes before the edge, then checks the registered buses just after it.
   task automatic step(input logic [1:0] ev, input logic [3:0] es, input string nm, output logic [2:0] a);
      logic fl;
      item_t it;
      #1;
      a = bus_if.req_valid_i & bus_if.req_ready_o;
      fl = bus_if.flush_i;
      @(posedge clk);
      if (fl) sbq.delete();
      for (int k = 0; k < 3; k++)
         if (a[k]) begin
            it.src = 2'(k);
            it.d = bus_if.req_data_i[k*32 +: 32];
            it.t = bus_if.req_tag_i[k*6 +: 6];
            it.we = bus_if.req_rrf_we_i[k];
            sbq.push_back(it);
         end
      #1;
      chk({nm, ".valid"}, 64'(bus_if.cdb_valid_o), 64'(ev));
      chk({nm, ".src"}, 64'(bus_if.cdb_src_o), 64'(es));
      for (int b = 0; b < 2; b++) begin
         logic [1:0] s;
         int idx;
         s = bus_if.cdb_src_o[b*2 +: 2];
         idx = -1;
         if (bus_if.cdb_valid_o[b]) begin
            foreach (sbq[q]) if (idx < 0 && sbq[q].src == s) idx = q;
            chk($sformatf("%s.b%0d.found", nm, b), 64'(idx >= 0), 64'd1);
            if (idx >= 0) begin
               chk($sformatf("%s.b%0d.data", nm, b), 64'(bus_if.cdb_data_o[b*32 +: 32]), 64'(sbq[idx].d));
               chk($sformatf("%s.b%0d.tag", nm, b), 64'(bus_if.cdb_tag_o[b*6 +: 6]), 64'(sbq[idx].t));
               chk($sformatf("%s.b%0d.we", nm, b), 64'(bus_if.cdb_rrf_we_o[b]), 64'(sbq[idx].we));
               sbq.delete(idx);
            end
         end else begin
            chk($sformatf("%s.b%0d.idle", nm, b),
                64'({bus_if.cdb_data_o[b*32 +: 32], bus_if.cdb_tag_o[b*6 +: 6], bus_if.cdb_rrf_we_o[b]}), 64'd0);
         end
      end
   endtask

   task automatic do_reset(input string nm);
      bus_if.flush_i = 1'b0;
      bus_if.req_valid_i = '0;
      bus_if.req_data_i = '0;
      bus_if.req_tag_i = '0;
      bus_if.req_rrf_we_i = '0;
      rst_n = 1'b0;
      sbq.delete();
      #1;
      chk({nm, ".async_valid"}, 64'(bus_if.cdb_valid_o), 64'd0);
      chk({nm, ".async_data"}, 64'(bus_if.cdb_data_o), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk({nm, ".ready"}, 64'(bus_if.req_ready_o), 64'h7);
      chk({nm, ".outs"}, 64'({bus_if.cdb_valid_o, bus_if.cdb_tag_o, bus_if.cdb_rrf_we_o, bus_if.cdb_src_o}), 64'd0);
   endtask

   initial begin
      do_reset("reset");

      drive(0, 1'b1, 32'hDEADBEEF, 6'd5, 1'b1);
      step(2'b00, 4'b0000, "single.e0", acc);
      drive(0, 1'b0, 32'h0, 6'd0, 1'b0);
      step(2'b01, 4'b0000, "single.e1", acc);
      step(2'b00, 4'b0000, "single.e2", acc);

      do_reset("reset2");
      for (int k = 0; k < 3; k++) drive(k, 1'b1, 32'hA000_0000 + 32'(k), 6'(10 + k), 1'b1);
      step(2'b00, 4'b0000, "cont.e0", acc);
      bus_if.req_valid_i = '0;
      step(2'b11, 4'b0100, "cont.e1", acc);
      step(2'b01, 4'b0010, "cont.e2", acc);
      step(2'b00, 4'b0000, "cont.e3", acc);

      for (int k = 0; k < 3; k++) begin
         seq[k] = '0;
         drive(k, 1'b1, {8'(k), seq[k]}, 6'(k * 16), 1'b1);
      end
      for (int n = 0; n < 12; n++) begin
         step(n == 0 ? 2'b00 : 2'b11, n == 0 ? 4'b0000 : pat[(n - 1) % 3], $sformatf("sus%0d", n), acc);
         if (n > 0) nres += $countones(bus_if.cdb_valid_o);
         for (int k = 0; k < 3; k++)
            if (acc[k]) begin
               seq[k] = seq[k] + 24'd1;
               drive(k, 1'b1, {8'(k), seq[k]}, 6'(k * 16) + 6'(seq[k][3:0]), seq[k][0]);
            end
      end
      bus_if.req_valid_i = '0;
      step(2'b11, 4'b1001, "sus12", acc);
      nres += $countones(bus_if.cdb_valid_o);
      chk("sustain.count", 64'(nres), 64'd24);
      step(2'b01, 4'b0000, "sus13", acc);
      step(2'b00, 4'b0000, "sus14", acc);
      chk("sustain.drained", 64'(sbq.size()), 64'd0);

      drive(2, 1'b1, 32'h5A5A_5A5A, 6'd33, 1'b0);
      step(2'b00, 4'b0000, "store.e0", acc);
      drive(2, 1'b0, 32'h0, 6'd0, 1'b0);
      step(2'b01, 4'b0010, "store.e1", acc);
      step(2'b00, 4'b0000, "store.e2", acc);

      drive(0, 1'b1, 32'h1111_0000, 6'd40, 1'b1);
      drive(2, 1'b1, 32'h2222_0000, 6'd42, 1'b1);
      step(2'b00, 4'b0000, "flush.load", acc);
      drive(0, 1'b0, 32'h0, 6'd0, 1'b0);
      drive(2, 1'b0, 32'h0, 6'd0, 1'b0);
      drive(1, 1'b1, 32'h3333_0000, 6'd41, 1'b1);
      bus_if.flush_i = 1'b1;
      #1 chk("flush.ready", 64'(bus_if.req_ready_o), 64'd0);
      step(2'b00, 4'b0000, "flush.e1", acc);
      bus_if.flush_i = 1'b0;
      drive(1, 1'b0, 32'h0, 6'd0, 1'b0);
      #1 chk("flush.ready_after", 64'(bus_if.req_ready_o), 64'h7);
      step(2'b00, 4'b0000, "flush.e2", acc);
      step(2'b00, 4'b0000, "flush.e3", acc);
      chk("flush.sb_empty", 64'(sbq.size()), 64'd0);

      for (int k = 0; k < 3; k++) drive(k, 1'b1, 32'hC000_0000 + 32'(k), 6'(50 + k), 1'b1);
      step(2'b00, 4'b0000, "areset.e0", acc);
      bus_if.req_valid_i = '0;
      step(2'b11, 4'b0100, "areset.e1", acc);
      do_reset("areset");
      step(2'b00, 4'b0000, "areset.after", acc);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
